// File: rtl/imm_decode_ctrl_pkg.sv
// Shared types for the immediate decode controller: immediate selector, opcodes, skid states.
// Optional vector immediate support is enabled by defining RVV_IMM_EN.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_Z    = 3'd5,
    IMM_V    = 3'd6,
    IMM_NONE = 3'd7
  } imm_sel_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OP_V   = 7'h57;

endpackage

// File: rtl/imm_decode_ctrl_sign_extend.sv
// signExtend: builds the five standard RISC-V immediates from instruction bits [31:7].
// Bit k of instr_hi corresponds to instruction bit k+7.
module signExtend (
  input  logic [24:0] instr_hi,
  output logic [31:0] imm_i,
  output logic [31:0] imm_s,
  output logic [31:0] imm_b,
  output logic [31:0] imm_u,
  output logic [31:0] imm_j
);

  assign imm_i = {{20{instr_hi[24]}}, instr_hi[24:13]};
  assign imm_s = {{20{instr_hi[24]}}, instr_hi[24:18], instr_hi[4:0]};
  assign imm_b = {{19{instr_hi[24]}}, instr_hi[24], instr_hi[0], instr_hi[23:18],
                  instr_hi[4:1], 1'b0};
  assign imm_u = {instr_hi[24:5], 12'b0};
  assign imm_j = {{11{instr_hi[24]}}, instr_hi[24], instr_hi[12:5], instr_hi[13],
                  instr_hi[23:14], 1'b0};

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage immediate selector feeding a 2-entry skid buffer with valid/ready handshakes.
// Define RVV_IMM_EN to decode vsetivli immediates and expose out_vtypei.
module imm_decode_ctrl
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic [PC_W-1:0] out_pc,
`ifdef RVV_IMM_EN
  output logic [9:0]      out_vtypei,
`endif
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_sel_t        sel;
    logic [PC_W-1:0] pc;
    logic            illegal;
`ifdef RVV_IMM_EN
    logic [9:0]      vtypei;
`endif
  } entry_t;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  signExtend u_sign_extend (
    .instr_hi (in_instr[31:7]),
    .imm_i    (imm_i),
    .imm_s    (imm_s),
    .imm_b    (imm_b),
    .imm_u    (imm_u),
    .imm_j    (imm_j)
  );

  entry_t dec;
  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  always_comb begin
    dec         = '0;
    dec.sel     = IMM_NONE;
    dec.pc      = in_pc;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        dec.sel = IMM_I;
        dec.imm = imm_i;
      end
      OPC_STORE: begin
        dec.sel = IMM_S;
        dec.imm = imm_s;
      end
      OPC_BRANCH: begin
        dec.sel = IMM_B;
        dec.imm = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.sel = IMM_U;
        dec.imm = imm_u;
      end
      OPC_JAL: begin
        dec.sel = IMM_J;
        dec.imm = imm_j;
      end
      OPC_SYSTEM: begin
        // CSR immediate forms carry a 5-bit zero-extended uimm in the rs1 field
        if (funct3[2]) begin
          dec.sel = IMM_Z;
          dec.imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
        end else begin
          dec.sel = IMM_I;
          dec.imm = imm_i;
        end
      end
      OPC_OP, OPC_FENCE: begin
        dec.sel = IMM_NONE;
      end
`ifdef RVV_IMM_EN
      OPC_OP_V: begin
        if (funct3 == 3'b111 && in_instr[31:30] == 2'b11) begin
          dec.sel    = IMM_V;
          dec.imm    = {{(XLEN-5){1'b0}}, in_instr[19:15]};
          dec.vtypei = in_instr[29:20];
        end
      end
`endif
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  skid_state_t state_reg, state_next;
  entry_t      head_reg, skid_reg;
  logic        in_fire, out_fire;
  logic        load_head, load_skid, head_from_skid;

  // in_ready depends only on registered state, so there is no path from out_ready
  assign in_ready  = (state_reg != SKID_TWO);
  assign out_valid = (state_reg != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= SKID_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_head      = 1'b0;
    load_skid      = 1'b0;
    head_from_skid = 1'b0;
    case (state_reg)
      SKID_EMPTY: begin
        if (in_fire) begin
          load_head  = 1'b1;
          state_next = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (in_fire && !out_fire) begin
          load_skid  = 1'b1;
          state_next = SKID_TWO;
        end else if (out_fire && !in_fire) begin
          state_next = SKID_EMPTY;
        end else if (in_fire && out_fire) begin
          load_head = 1'b1;
        end
      end
      SKID_TWO: begin
        if (out_fire) begin
          head_from_skid = 1'b1;
          state_next     = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
    if (flush) begin
      state_next     = SKID_EMPTY;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg     <= '0;
      head_reg.sel <= IMM_NONE;
      skid_reg     <= '0;
      skid_reg.sel <= IMM_NONE;
    end else begin
      if (load_head) begin
        head_reg <= dec;
      end else if (head_from_skid) begin
        head_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= dec;
      end
    end
  end

  assign out_imm     = head_reg.imm;
  assign out_imm_sel = head_reg.sel;
  assign out_pc      = head_reg.pc;
  assign out_illegal = head_reg.illegal;
`ifdef RVV_IMM_EN
  assign out_vtypei  = head_reg.vtypei;
`endif

endmodule
